maxpool2x2: RTL and testbench
=============================

MAXPOOL2X2 -- requirements
Module: maxpool2x2

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, the pixel width in bits.
REQ-002 SHALL have parameter ROWS, default 480, the input frame height in pixels; the value SHALL be even.
REQ-003 SHALL have parameter COLS, default 640, the input frame width in pixels; the value SHALL be even.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port din_valid, input, 1 bit: a pixel is present on din this cycle; it is driven by the 3x3 filter dout_valid.
REQ-007 SHALL have port din, input, BITWIDTH bits: the unsigned filtered pixel, in row-major raster order.
REQ-008 SHALL have port dout, output, BITWIDTH bits: the pooled pixel, the maximum of one 2x2 block.
REQ-009 SHALL have port dout_valid, output, 1 bit: a one-cycle pulse marking dout as valid.
REQ-010 SHALL have port frame_done, output, 1 bit: a one-cycle pulse coincident with the last pooled output of a frame.

Function
REQ-011 SHALL keep a column counter (0..COLS-1) and a row counter (0..ROWS-1), both advanced only on cycles with din_valid=1.
- Column wraps to 0 after COLS-1 and increments row.
- Row wraps to 0 after ROWS-1 (end of frame); the next frame starts immediately with no idle cycle required.
REQ-012 SHALL hold both counters and all data registers unchanged on cycles with din_valid=0; gaps of any length and position SHALL NOT alter the results.
REQ-013 On an accepted pixel at even column, SHALL store din in a horizontal-hold register.
REQ-014 On an accepted pixel at odd column, SHALL form pair_max = max(hold, din) using an unsigned compare; ties yield the common value.
REQ-015 On an even row, SHALL write pair_max into a line buffer of COLS/2 entries at index column>>1, and SHALL produce no output.
REQ-016 On an odd row at odd column, SHALL register dout = max(linebuf[column>>1], pair_max) and assert dout_valid for exactly one cycle.
REQ-017 Latency: dout_valid SHALL rise on the cycle immediately after the clock edge that accepts the bottom-right pixel of a block.
- dout SHALL hold its value until the next output.
REQ-018 SHALL produce exactly (ROWS/2)*(COLS/2) outputs per frame, in raster order of the pooled image.
REQ-019 SHALL assert frame_done together with dout_valid for the output produced by pixel (ROWS-1, COLS-1), and at no other time.
REQ-020 The line buffer SHALL be inferred as memory or registers.
- Its entries are always written on an even row before being read on an odd row, so no clearing is required.
REQ-021 SHALL NOT apply backpressure; every pixel with din_valid=1 is consumed in its cycle.
REQ-022 All widths SHALL equal BITWIDTH; no saturation or scaling.

Reset
REQ-023 While rst=1 at a clock edge, SHALL set: column=0, row=0, hold=0, dout=0, dout_valid=0, frame_done=0; line buffer contents are don't-care.
REQ-024 Reset SHALL take priority over din_valid in the same cycle; that pixel is discarded.
REQ-025 Reset asserted mid-frame SHALL abandon the partial frame; the first pixel accepted after rst deasserts is pixel (0,0) of a new frame.
- No output from the abandoned frame SHALL appear.

Verification (BITWIDTH=8, ROWS=4, COLS=4)
REQ-026 Bench SHALL cover: frame of values 0..15 row-major, din_valid continuous -> dout = 5, 7, 13, 15 on four single-cycle pulses; frame_done with the 15.
REQ-027 Bench SHALL cover: the same frame with din_valid toggling 1/0 each cycle -> identical outputs, each output one cycle after its bottom-right pixel is accepted.
REQ-028 Bench SHALL cover: all pixels 255, then a frame where only pixel (3,0) is 200 and the rest are 0 -> 255 x4, then 0, 0, 200, 0.
REQ-029 Bench SHALL cover: 6 pixels fed, rst high for 1 cycle with din_valid=1, then the 0..15 frame -> exactly 5, 7, 13, 15 and one frame_done.
REQ-030 Bench SHALL cover: two 0..15 frames back-to-back with no gap -> eight outputs (5, 7, 13, 15 twice) and two frame_done pulses.
REQ-031 Bench SHALL cover: ties, a block of four equal 9s -> 9.

Source files
------------

// File: rtl/maxpool2x2.sv
// 2x2 max-pooling stage for a raster-order pixel stream.
// Pairs are maxed horizontally, then even-row results wait in a half-width line buffer
// to be maxed against the matching odd-row pair, giving one output per 2x2 block.
module maxpool2x2 #(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned ROWS     = 480,
    parameter int unsigned COLS     = 640
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    input  logic [BITWIDTH-1:0] din,
    output logic [BITWIDTH-1:0] dout,
    output logic                dout_valid,
    output logic                frame_done
);

    // Half-width index is the column counter without its LSB; needs COLS >= 4, ROWS >= 2.
    localparam int unsigned HalfCols = COLS / 2;
    localparam int unsigned IdxW     = $clog2(HalfCols);
    localparam int unsigned ColW     = IdxW + 1;
    localparam int unsigned RowW     = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);

    logic [ColW-1:0]     col_q;
    logic [RowW-1:0]     row_q;
    logic [BITWIDTH-1:0] hold_q;
    logic [BITWIDTH-1:0] linebuf [HalfCols];

    logic [IdxW-1:0]     col_idx;
    logic [BITWIDTH-1:0] pair_max;
    logic [BITWIDTH-1:0] lb_rd;
    logic [BITWIDTH-1:0] block_max;
    logic                col_last;
    logic                row_last;
    logic                lb_we;

    // Datapath: horizontal pair max, then vertical max against the buffered even row.
    always_comb begin
        col_idx   = col_q[IdxW:1];
        pair_max  = (din > hold_q) ? din : hold_q;
        lb_rd     = linebuf[col_idx];
        block_max = (lb_rd > pair_max) ? lb_rd : pair_max;
        col_last  = (col_q == ColLast);
        row_last  = (row_q == RowLast);
        lb_we     = !rst && din_valid && col_q[0] && !row_q[0];
    end

    // Line buffer: no reset, every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[col_idx] <= pair_max;
        end
    end

    // Raster counters, horizontal hold register and registered pooled output.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            hold_q     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            if (din_valid) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end

                if (!col_q[0]) begin
                    hold_q <= din;
                end else if (row_q[0]) begin
                    dout       <= block_max;
                    dout_valid <= 1'b1;
                    frame_done <= col_last && row_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2.sv
// Directed bench for maxpool2x2 on a 4x4 frame: checks pooled values, frame_done placement
// and the one-cycle latency from the accepting edge of each block's bottom-right pixel.
module tb_maxpool2x2;

    localparam int unsigned BW = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned C  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          din_valid;
    logic [BW-1:0] din;
    logic [BW-1:0] dout;
    logic          dout_valid;
    logic          frame_done;

    maxpool2x2 #(
        .BITWIDTH(BW),
        .ROWS    (R),
        .COLS    (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .dout      (dout),
        .dout_valid(dout_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int   got_val [$];
    int   got_fd  [$];
    int   got_cyc [$];
    int   exp_cyc [$];

    // Capture every cycle showing a valid or a frame_done, mid-cycle.
    always @(negedge clk) begin
        if (dout_valid === 1'b1 || frame_done === 1'b1) begin
            got_val.push_back(int'(dout));
            got_fd.push_back(int'(frame_done));
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_caps();
        got_val.delete();
        got_fd.delete();
        got_cyc.delete();
        exp_cyc.delete();
    endtask

    // Feed one 4x4 frame; toggle inserts an idle cycle after every pixel.
    task automatic send_frame(input logic [BW-1:0] px [16], input bit toggle);
        for (int i = 0; i < 16; i++) begin
            din_valid = 1'b1;
            din       = px[i];
            @(posedge clk);
            #1;
            if ((i / 4) % 2 == 1 && (i % 4) % 2 == 1) exp_cyc.push_back(cyc);
            if (toggle) begin
                din_valid = 1'b0;
                din       = 8'hEE;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare captured outputs; frame_done expected on every fourth output.
    task automatic verify(input string tag, input int ev [8], input int n);
        int m;
        chk({tag, "_count"}, got_val.size(), n);
        m = (got_val.size() < n) ? got_val.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_val%0d", tag, i), got_val[i], ev[i]);
            chk($sformatf("%s_fd%0d", tag, i), got_fd[i], (i % 4 == 3) ? 1 : 0);
            if (i < exp_cyc.size())
                chk($sformatf("%s_lat%0d", tag, i), got_cyc[i], exp_cyc[i]);
        end
        clear_caps();
    endtask

    logic [BW-1:0] f_seq  [16];
    logic [BW-1:0] f_ff   [16];
    logic [BW-1:0] f_one  [16];
    logic [BW-1:0] f_tie  [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            f_seq[i] = BW'(i);
            f_ff[i]  = 8'd255;
            f_one[i] = 8'd0;
            f_tie[i] = BW'(i);
        end
        f_one[12] = 8'd200;          // pixel (3,0)
        f_tie[0]  = 8'd9;
        f_tie[1]  = 8'd9;
        f_tie[4]  = 8'd9;
        f_tie[5]  = 8'd9;

        // Reset with a pixel present: it must be discarded.
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_fd", int'(frame_done), 0);
        rst       = 1'b0;
        din_valid = 1'b0;
        clear_caps();
        idle(1);

        send_frame(f_seq, 1'b0);
        idle(3);
        verify("seq", '{5, 7, 13, 15, 0, 0, 0, 0}, 4);

        send_frame(f_seq, 1'b1);
        idle(3);
        verify("gap", '{5, 7, 13, 15, 0, 0, 0, 0}, 4);

        send_frame(f_ff, 1'b0);
        send_frame(f_one, 1'b0);
        idle(3);
        verify("ff_one", '{255, 255, 255, 255, 0, 0, 200, 0}, 8);

        // Abandon a frame after 6 pixels via a one-cycle reset carrying a valid pixel.
        for (int i = 0; i < 6; i++) begin
            din_valid = 1'b1;
            din       = f_seq[i];
            @(posedge clk);
            #1;
        end
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 8'd99;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        din_valid = 1'b0;
        clear_caps();
        @(negedge clk);
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_valid", int'(dout_valid), 0);
        #1;
        send_frame(f_seq, 1'b0);
        idle(3);
        verify("midrst", '{5, 7, 13, 15, 0, 0, 0, 0}, 4);

        send_frame(f_seq, 1'b0);
        send_frame(f_seq, 1'b0);
        idle(3);
        verify("b2b", '{5, 7, 13, 15, 5, 7, 13, 15}, 8);

        send_frame(f_tie, 1'b0);
        idle(3);
        verify("tie", '{9, 7, 13, 15, 0, 0, 0, 0}, 4);

        // dout holds its last value between outputs.
        idle(2);
        chk("hold_dout", int'(dout), 15);
        chk("quiet_valid", got_val.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
